// File: rtl/seq_compar_pkg.sv
// Shared types and defaults for the seq_compar multi-cycle magnitude comparator.
package seq_compar_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } result_t;

    // Collapse the one-hot result flags into the consumer-facing encoding.
    function automatic result_t encode_result(input logic aeqb, input logic agtb);
        result_t res;
        if (aeqb) begin
            res = EQ;
        end else if (agtb) begin
            res = GT;
        end else begin
            res = LT;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_compar_if.sv
// start/busy/done compare handshake with operands and registered result flags.
interface seq_compar_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, aeqb, agtb, altb
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, aeqb, agtb, altb
    );
endinterface

// File: rtl/seq_compar_slice.sv
// compar_slice: combinational CHUNK-bit cascade cell carrying equal/greater from the more significant slices.
module compar_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] sa,
    input  logic [CHUNK-1:0] sb,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             eq_out,
    output logic             gt_out
);

    // A more significant difference always dominates this slice's verdict.
    always_comb begin
        eq_out = eq_in & (sa == sb);
        gt_out = gt_in | (eq_in & (sa > sb));
    end

endmodule

// File: rtl/seq_compar.sv
// seq_compar: MSB-first multi-cycle magnitude comparator, one CHUNK slice per clock.
// Optional build macro SEQ_COMPAR_EARLY_EXIT_EN stops the walk at the first unequal slice.
module seq_compar
    import seq_compar_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic         clk,
    input logic         rst,
    seq_compar_if.slave bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [IDX_W-1:0]   idx_r;
    logic               eq_r;
    logic               gt_r;
    logic               eq_next_s;
    logic               gt_next_s;
    logic               last_s;
    logic               exit_s;
    logic               accept_s;
    logic               aeqb_r;
    logic               agtb_r;
    logic               altb_r;
    logic               busy_s;
    logic               done_s;

    assign accept_s = bus.start & (state_r != RUN);
    assign last_s   = (idx_r == IDX_W'(N - 1));

`ifdef SEQ_COMPAR_EARLY_EXIT_EN
    assign exit_s = last_s | ~eq_next_s;
`else
    assign exit_s = last_s;
`endif

    // The operands shift left each cycle, so the current slice is always the top CHUNK bits.
    compar_slice #(.CHUNK(CHUNK)) u_slice (
        .sa     (a_r[WIDTH-1 -: CHUNK]),
        .sb     (b_r[WIDTH-1 -: CHUNK]),
        .eq_in  (eq_r),
        .gt_in  (gt_r),
        .eq_out (eq_next_s),
        .gt_out (gt_next_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (exit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            RUN:     busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand capture, slice walk and result registers.
    // Flipping both MSBs in signed mode maps two's-complement order onto unsigned order.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            eq_r   <= 1'b1;
            gt_r   <= 1'b0;
            aeqb_r <= 1'b0;
            agtb_r <= 1'b0;
            altb_r <= 1'b0;
        end else if (accept_s) begin
            a_r    <= {bus.a[WIDTH-1] ^ bus.is_signed, bus.a[WIDTH-2:0]};
            b_r    <= {bus.b[WIDTH-1] ^ bus.is_signed, bus.b[WIDTH-2:0]};
            idx_r  <= {IDX_W{1'b0}};
            eq_r   <= 1'b1;
            gt_r   <= 1'b0;
        end else if (state_r == RUN) begin
            a_r   <= a_r << CHUNK;
            b_r   <= b_r << CHUNK;
            idx_r <= idx_r + IDX_W'(1);
            eq_r  <= eq_next_s;
            gt_r  <= gt_next_s;
            if (exit_s) begin
                aeqb_r <= eq_next_s;
                agtb_r <= gt_next_s;
                altb_r <= ~eq_next_s & ~gt_next_s;
            end
        end
    end

    assign bus.busy = busy_s;
    assign bus.done = done_s;
    assign bus.aeqb = aeqb_r;
    assign bus.agtb = agtb_r;
    assign bus.altb = altb_r;

endmodule

// File: tb/tb_seq_compar.sv
// Self-checking bench for seq_compar: directed cases from the compare rules plus randomized operands.
module tb_seq_compar;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_compar_if #(.WIDTH(WIDTH)) bus ();

    seq_compar #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {eq, gt, lt} from whole-operand arithmetic.
    function automatic logic [2:0] exp_res(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic gt;
        if (x == y) return 3'b100;
        gt = sgn ? ($signed(x) > $signed(y)) : (x > y);
        return gt ? 3'b010 : 3'b001;
    endfunction

    // Cycles from accept edge to done: index of first differing slice plus one when early exit is built in.
    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x ^ y;
`ifdef SEQ_COMPAR_EARLY_EXIT_EN
        for (int i = 0; i < N; i++) begin
            if (((d >> (WIDTH - CHUNK * (i + 1))) & 32'hF) != 32'h0) return i + 1;
        end
`endif
        return (d == 32'h0) ? N : N;
    endfunction

    task automatic do_cmp(input logic [31:0] ta, input logic [31:0] tbv, input logic sgn,
                          input bit keep, input string tag);
        int lat;
        lat = 0;
        bus.start     = 1'b1;
        bus.a         = ta;
        bus.b         = tbv;
        bus.is_signed = sgn;
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        if (!keep) bus.start = 1'b0;
        for (int i = 1; i <= N + 2; i++) begin
            if (keep) begin
                bus.a         = $urandom;
                bus.b         = $urandom;
                bus.is_signed = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat(ta, tbv));
        chk({tag, "_res"}, {29'd0, bus.aeqb, bus.agtb, bus.altb}, {29'd0, exp_res(ta, tbv, sgn)});
        if (!keep) begin
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen;
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {27'd0, bus.busy, bus.done, bus.aeqb, bus.agtb, bus.altb}, 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        do_cmp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, "eq_u");
        do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, "msb_u");
        do_cmp(32'h80000000, 32'h00000001, 1'b1, 1'b0, "neg_s");
        do_cmp(32'h80000000, 32'h00000001, 1'b0, 1'b0, "neg_u");
        do_cmp(32'h00000010, 32'h00000011, 1'b0, 1'b0, "lsb_u");
        do_cmp(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, "m1_s");

        // start held high: new operands in every done cycle, junk operands while busy
        for (int k = 0; k < 6; k++) begin
            do_cmp($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, "b2b");
        end
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset arriving at slice 3 aborts the compare silently
        bus.start = 1'b1;
        bus.a     = 32'h00000001;
        bus.b     = 32'h00000002;
        bus.is_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid", {27'd0, bus.busy, bus.done, bus.aeqb, bus.agtb, bus.altb}, 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1;
        end
        chk("rst_nodone", seen, 0);
        do_cmp(32'h12345678, 32'h12345679, 1'b0, 1'b0, "post_rst");

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = ra;
                default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
            endcase
            do_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
